gen12_multilane_scramble: RTL and testbench
===========================================

Name: gen12_multilane_scramble

Overview:
Parametrised multi-lane Gen1/Gen2 (8b/10b-era) transmit scrambler between the datalink/ordered-set mux and the per-lane PIPE TX interface. Each lane runs its own LFSR (x^16+x^5+x^4+x^3+1) and ordered-set tracker. The block supports runtime PIPE widths of 8/16/32 bits, a per-lane active mask and a global scrambling-disable. It adds explicit TS/SKP ordered-set state machines, LFSR hold on idle cycles and a fixed two-cycle latency.

Parameters:
NUM_LANES, 4, number of independent lanes (1..16)
MAX_BYTES, 4, max symbols per lane per cycle; lane slice width = MAX_BYTES*8
SEED, 16'hFFFF, LFSR reset/COM initialisation value

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
pipe_width_i  in  6  PIPE width 8/16/32; bytes per lane B = pipe_width_i>>3; changes only while data_valid_i=0
lane_active_i  in  NUM_LANES  per-lane enable
scramble_disable_i  in  1  1 = D symbols pass unscrambled; LFSR still tracks
data_valid_i  in  1  input word valid, common to all lanes
data_i  in  NUM_LANES*MAX_BYTES*8  lane L byte j at [(L*MAX_BYTES+j)*8 +: 8]; byte 0 is first in time
data_k_i  in  NUM_LANES*MAX_BYTES  K flag per byte, same indexing
data_valid_o  out  1  output valid
data_o  out  NUM_LANES*MAX_BYTES*8  scrambled data
data_k_o  out  NUM_LANES*MAX_BYTES  K flags, delayed copy of the input flags

Behaviour:
- Reset: all outputs 0; every LFSR = SEED; every lane state = DATA; os_cnt = 0.
- Latency: 2 cycles, fixed. Stage 1 registers the inputs. Stage 2 computes and registers the outputs. data_valid_o, data_k_o and data_o stay aligned.
- Key: key for LFSR state S is bit-reverse of S[15:8]. Advance = 8 serial shifts. From SEED the keys are FF,17,C0,14,B2,E7,02,82.
- Byte processing: bytes 0..B-1 of a lane are processed sequentially within one cycle; each byte sees the LFSR/state left by the previous byte.
- Bytes j >= B: output 0, K flag 0.
- Per-byte rules, in priority order:
  - COM (K, 8'hBC): output unscrambled. LFSR := SEED without advance. state := AFTER_COM.
  - SKP (K, 8'h1C) in SKP_OS or AFTER_COM: output unscrambled, LFSR not advanced, state := SKP_OS.
  - Any other K: output unscrambled, LFSR advances.
  - D symbol: output = data XOR key unless one of these holds: state in {TS_OS, AFTER_COM->TS_OS transition}, scramble_disable_i=1, or lane inactive. LFSR advances in every case.
- Lane state machine:
  - DATA: changes only on COM.
  - AFTER_COM, next symbol:
    - SKP -> SKP_OS.
    - D or PAD (K 8'hF7) -> TS_OS with os_cnt = 14 (this symbol is TS symbol 1, unscrambled).
    - Other K (IDL/FTS/EIE) -> DATA.
  - SKP_OS: SKP stays. First non-SKP returns to DATA and is processed under DATA rules in the same byte slot.
  - TS_OS: each symbol decrements os_cnt. Symbol processed with os_cnt=1 exits to DATA. COM inside TS_OS restarts per the COM rule.
- data_valid_i=0: no LFSR or state update. Output valid 0, data 0 two cycles later.
- lane_active_i[L]=0: that lane's LFSR held at SEED, state DATA, outputs 0. Reactivation starts from SEED.
- scramble_disable_i toggling mid-word takes effect on the next valid word. The LFSR sequence is unaffected.
- A COM in the last byte slot leaves state AFTER_COM across the cycle boundary. The cross-cycle result must equal the same-cycle result.
- Reset asserted mid-operation: next cycle all state is at reset values; in-flight words are discarded.

Test Plan:
- Lane 0, B=4: COM,00,00,00 then 00,00,00,00 (D), state reached via COM followed by K IDL -> outputs BC,00?,...
  - Correction to this scenario: use COM then IDL(K 7C), then D 00 x6 -> outputs BC,7C, then the keys from SEED advanced one IDL step.
  - Expected values are from the model; the bench checks against the reference LFSR model.
- Direct-key check: COM, then eight D 00 bytes, with the D stream directly following COM under disable via AFTER_COM->DATA through FTS.
  - Simpler equivalent for bench: after reset with no COM, eight D 00 at B=1 -> FF,17,C0,14,B2,E7,02,82.
- SKP OS: COM,SKP,SKP,SKP then D 00 x2 at B=4 -> 1C bytes pass unscrambled. The D bytes equal the keys following the COM reset with no advance for SKPs: FF,17.
- TS1: COM + 15 D bytes (0x4A) -> all 15 output 4A unscrambled. The 17th byte (D 00) scrambles with the 16th key from SEED.
- B=2, NUM_LANES=4: COM in byte 1 of cycle n, D byte in cycle n+1 -> same output as B=4. Lanes with lane_active_i=0 output 0.
- Mid-stream rst_i pulse and data_valid_i gaps -> outputs 0 for 2 cycles. After reset, the D 00 stream restarts at FF,17. Gaps do not advance the LFSR.

Source files
------------

// File: rtl/gen12_multilane_scramble.sv
// Multi-lane Gen1/Gen2 TX scrambler with per-lane LFSR and ordered-set
// tracking; inputs registered in stage 1, lanes processed in stage 2.
module gen12_multilane_scramble #(
    parameter int          NUM_LANES = 4,
    parameter int          MAX_BYTES = 4,
    parameter logic [15:0] SEED      = 16'hFFFF
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [5:0]                       pipe_width_i,
    input  logic [NUM_LANES-1:0]             lane_active_i,
    input  logic                             scramble_disable_i,
    input  logic                             data_valid_i,
    input  logic [NUM_LANES*MAX_BYTES*8-1:0] data_i,
    input  logic [NUM_LANES*MAX_BYTES-1:0]   data_k_i,
    output logic                             data_valid_o,
    output logic [NUM_LANES*MAX_BYTES*8-1:0] data_o,
    output logic [NUM_LANES*MAX_BYTES-1:0]   data_k_o
);
    localparam int LW = MAX_BYTES * 8;
    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_SKP = 8'h1C;
    localparam logic [7:0] SYM_PAD = 8'hF7;

    typedef enum logic [1:0] {
        ST_DATA, ST_AFTER_COM, ST_SKP_OS, ST_TS_OS
    } lane_st_t;

    typedef struct packed {
        logic [15:0] lfsr;
        lane_st_t    st;
        logic [3:0]  os_cnt;
    } lane_ctx_t;

    localparam lane_ctx_t CTX_RST = '{lfsr: SEED, st: ST_DATA, os_cnt: 4'd0};

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 8; i++)
            r = {r[14:0], 1'b0} ^ (r[15] ? 16'h0039 : 16'h0000);
        return r;
    endfunction

    function automatic logic [7:0] lfsr_key(input logic [7:0] h);
        logic [7:0] kb;
        for (int i = 0; i < 8; i++)
            kb[i] = h[7-i];
        return kb;
    endfunction

    // Walks bytes 0..nb-1 in time order; each byte sees the context
    // left by the previous one.
    function automatic lane_ctx_t lane_step(
        input  lane_ctx_t              c,
        input  logic [LW-1:0]          d,
        input  logic [MAX_BYTES-1:0]   k,
        input  logic [2:0]             nb,
        input  logic                   dis,
        output logic [LW-1:0]          dq,
        output logic [MAX_BYTES-1:0]   kq
    );
        lane_ctx_t  n;
        logic [7:0] b;
        logic       scr;
        n  = c;
        dq = '0;
        kq = '0;
        for (int j = 0; j < MAX_BYTES; j++) begin
            if (j < int'(nb)) begin
                b     = d[j*8 +: 8];
                kq[j] = k[j];
                scr   = 1'b0;
                if (k[j] && b == SYM_COM) begin
                    n.lfsr = SEED;
                    n.st   = ST_AFTER_COM;
                end else if (k[j] && b == SYM_SKP &&
                             (n.st == ST_SKP_OS || n.st == ST_AFTER_COM)) begin
                    n.st = ST_SKP_OS;
                end else begin
                    case (n.st)
                        ST_AFTER_COM: begin
                            if (!k[j] || b == SYM_PAD) begin
                                n.st     = ST_TS_OS;
                                n.os_cnt = 4'd14;
                            end else begin
                                n.st = ST_DATA;
                            end
                        end
                        ST_TS_OS: begin
                            if (n.os_cnt == 4'd1) begin
                                n.st     = ST_DATA;
                                n.os_cnt = 4'd0;
                            end else begin
                                n.os_cnt = n.os_cnt - 4'd1;
                            end
                        end
                        ST_SKP_OS: begin
                            n.st = ST_DATA;
                            scr  = !k[j];
                        end
                        default: scr = !k[j];
                    endcase
                    if (scr && !dis)
                        b = b ^ lfsr_key(n.lfsr[15:8]);
                    n.lfsr = lfsr_adv(n.lfsr);
                end
                dq[j*8 +: 8] = b;
            end
        end
        return n;
    endfunction

    logic                             v1;
    logic [2:0]                       nb1;
    logic [NUM_LANES-1:0]             act1;
    logic                             dis1;
    logic [NUM_LANES*MAX_BYTES*8-1:0] d1;
    logic [NUM_LANES*MAX_BYTES-1:0]   k1;

    lane_ctx_t            ctx     [NUM_LANES];
    lane_ctx_t            nxt_ctx [NUM_LANES];
    logic [LW-1:0]        lane_dq [NUM_LANES];
    logic [MAX_BYTES-1:0] lane_kq [NUM_LANES];

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            nxt_ctx[l] = lane_step(ctx[l], d1[l*LW +: LW],
                                   k1[l*MAX_BYTES +: MAX_BYTES],
                                   nb1, dis1, lane_dq[l], lane_kq[l]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1           <= 1'b0;
            nb1          <= 3'd0;
            act1         <= '0;
            dis1         <= 1'b0;
            d1           <= '0;
            k1           <= '0;
            data_valid_o <= 1'b0;
            data_o       <= '0;
            data_k_o     <= '0;
            for (int l = 0; l < NUM_LANES; l++)
                ctx[l] <= CTX_RST;
        end else begin
            v1           <= data_valid_i;
            nb1          <= 3'(pipe_width_i >> 3);
            act1         <= lane_active_i;
            dis1         <= scramble_disable_i;
            d1           <= data_i;
            k1           <= data_k_i;
            data_valid_o <= v1;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (!act1[l]) begin
                    ctx[l]                            <= CTX_RST;
                    data_o[l*LW +: LW]                <= '0;
                    data_k_o[l*MAX_BYTES +: MAX_BYTES] <= '0;
                end else if (v1) begin
                    ctx[l]                            <= nxt_ctx[l];
                    data_o[l*LW +: LW]                <= lane_dq[l];
                    data_k_o[l*MAX_BYTES +: MAX_BYTES] <= lane_kq[l];
                end else begin
                    data_o[l*LW +: LW]                <= '0;
                    data_k_o[l*MAX_BYTES +: MAX_BYTES] <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gen12_multilane_scramble.sv
// Scoreboard bench for gen12_multilane_scramble: directed words push
// expected results, a monitor pops and compares on every output cycle.
module tb_gen12_multilane_scramble;
    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [5:0]   pipe_width_i;
    logic [3:0]   lane_active_i;
    logic         scramble_disable_i;
    logic         data_valid_i;
    logic [127:0] data_i;
    logic [15:0]  data_k_i;
    logic         data_valid_o;
    logic [127:0] data_o;
    logic [15:0]  data_k_o;

    int checks   = 0;
    int failures = 0;
    logic [143:0] exp_q [$];

    logic [7:0] keys [8] = '{8'hFF, 8'h17, 8'hC0, 8'h14,
                             8'hB2, 8'hE7, 8'h02, 8'h82};

    gen12_multilane_scramble dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .pipe_width_i       (pipe_width_i),
        .lane_active_i      (lane_active_i),
        .scramble_disable_i (scramble_disable_i),
        .data_valid_i       (data_valid_i),
        .data_i             (data_i),
        .data_k_i           (data_k_i),
        .data_valid_o       (data_valid_o),
        .data_o             (data_o),
        .data_k_o           (data_k_o)
    );

    always #5 clk_i = ~clk_i;

    // Serial reference scrambler: key n is the byte after n advances from FFFF.
    function automatic logic [7:0] key_n(input int n);
        logic [15:0] s;
        logic [7:0]  kb;
        s = 16'hFFFF;
        for (int i = 0; i < n * 8; i++)
            s = s[15] ? ({s[14:0], 1'b0} ^ 16'h0039) : {s[14:0], 1'b0};
        for (int b = 0; b < 8; b++)
            kb[b] = s[15-b];
        return kb;
    endfunction

    function automatic logic [127:0] rep32(input logic [31:0] x);
        return {4{x}};
    endfunction

    function automatic logic [15:0] rep4(input logic [3:0] x);
        return {4{x}};
    endfunction

    task automatic send(input logic [127:0] d, input logic [15:0] k,
                        input logic [127:0] ed, input logic [15:0] ek,
                        input bit push = 1'b1);
        data_i       = d;
        data_k_i     = k;
        data_valid_i = 1'b1;
        if (push) begin
            for (int l = 0; l < 4; l++) begin
                if (!lane_active_i[l]) begin
                    ed[l*32 +: 32] = '0;
                    ek[l*4 +: 4]   = '0;
                end
            end
            exp_q.push_back({ed, ek});
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            data_valid_i = 1'b0;
            data_i       = rep32(32'hBCBC_BCBC);
            data_k_i     = '1;
            @(negedge clk_i);
        end
    endtask

    initial begin
        logic [143:0] e;
        @(posedge clk_i);
        forever begin
            @(negedge clk_i);
            if (data_valid_o) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid got d=%h k=%h want none",
                             data_o, data_k_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({data_o, data_k_o} !== e) begin
                        failures++;
                        $display("FAIL word got d=%h k=%h want d=%h k=%h",
                                 data_o, data_k_o, e[143:16], e[15:0]);
                    end
                end
            end else begin
                checks++;
                if (data_o !== '0 || data_k_o !== '0) begin
                    failures++;
                    $display("FAIL idle_zero got d=%h k=%h want 0",
                             data_o, data_k_o);
                end
            end
        end
    end

    initial begin
        rst_i              = 1'b1;
        pipe_width_i       = 6'd32;
        lane_active_i      = 4'hF;
        scramble_disable_i = 1'b0;
        data_valid_i       = 1'b0;
        data_i             = '0;
        data_k_i           = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // B=1 from reset: raw key stream; K bytes beyond B must be ignored
        pipe_width_i = 6'd8;
        for (int i = 0; i < 8; i++)
            send(rep32(32'hBCBC_BC00), rep4(4'b1110),
                 rep32({24'h0, keys[i]}), 16'h0);

        // COM, IDL, then six D 00
        pipe_width_i = 6'd32;
        send(rep32(32'h0000_7CBC), rep4(4'b0011),
             rep32(32'hC017_7CBC), rep4(4'b0011));
        send(rep32(32'h0), 16'h0, rep32(32'h02E7_B214), 16'h0);

        // SKP ordered set, then disabled and re-enabled data
        send(rep32(32'h1C1C_1CBC), rep4(4'hF),
             rep32(32'h1C1C_1CBC), rep4(4'hF));
        send(rep32(32'h0), 16'h0, rep32(32'h14C0_17FF), 16'h0);
        scramble_disable_i = 1'b1;
        send(rep32(32'h5A5A_5A5A), 16'h0, rep32(32'h5A5A_5A5A), 16'h0);
        scramble_disable_i = 1'b0;
        send(rep32(32'h0), 16'h0,
             rep32({key_n(11), key_n(10), key_n(9), key_n(8)}), 16'h0);

        // TS ordered set: COM + 15 unscrambled symbols
        send(rep32(32'h4A4A_4ABC), rep4(4'b0001),
             rep32(32'h4A4A_4ABC), rep4(4'b0001));
        repeat (3)
            send(rep32(32'h4A4A_4A4A), 16'h0, rep32(32'h4A4A_4A4A), 16'h0);
        send(rep32(32'h0), 16'h0,
             rep32({key_n(18), key_n(17), key_n(16), key_n(15)}), 16'h0);

        // B=2, COM in last slot, lane 2 inactive
        pipe_width_i  = 6'd16;
        lane_active_i = 4'b1011;
        send(rep32(32'hBCBC_BC7C), rep4(4'b1111),
             rep32(32'h0000_BC7C), rep4(4'b0011));
        send(rep32(32'hBCBC_007C), rep4(4'b1101),
             rep32(32'h0000_177C), rep4(4'b0001));
        send(rep32(32'hBCBC_0000), rep4(4'b1100),
             rep32(32'h0000_14C0), 16'h0);
        lane_active_i = 4'hF;
        send(rep32(32'hBCBC_0000), rep4(4'b1100),
             {32'h0000_E7B2, 32'h0000_17FF, 32'h0000_E7B2, 32'h0000_E7B2},
             16'h0);

        // Gaps hold the LFSR; reset discards the in-flight word
        pipe_width_i = 6'd32;
        send(rep32(32'h0000_7CBC), rep4(4'b0011),
             rep32(32'hC017_7CBC), rep4(4'b0011));
        idle(3);
        send(rep32(32'h0), 16'h0, rep32(32'h02E7_B214), 16'h0);
        send(rep32(32'h0), 16'h0, rep32(32'h0), 16'h0, 1'b0);
        rst_i        = 1'b1;
        data_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        idle(2);
        send(rep32(32'h0), 16'h0, rep32(32'h14C0_17FF), 16'h0);
        idle(4);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending words want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
